// File: rtl/byte_stream_fifo.sv
// rtl/byte_stream_fifo.sv - first-word-fall-through byte FIFO; optional level/almost-full ports via BYTE_FIFO_LEVEL_EN
module byte_stream_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     s_valid_i,
    input  logic [DATA_W-1:0]        s_data_i,
    output logic                     s_ready_o,
    output logic                     m_valid_o,
    output logic [DATA_W-1:0]        m_data_o,
    input  logic                     m_ready_i
`ifdef BYTE_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     almost_full_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              full, empty, push, pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign s_ready_o = !full;
    assign m_valid_o = !empty;
    assign m_data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push = s_valid_i && !full && !flush_i;
    assign pop  = m_ready_i && !empty && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_data_i;
        end
    end

`ifdef BYTE_FIFO_LEVEL_EN
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    // Modular pointer difference yields 0..DEPTH directly.
    assign level_o       = wr_ptr_q - rd_ptr_q;
    assign almost_full_o = (level_o >= AFULL_LVL);
`endif

endmodule

// File: tb/tb_byte_stream_fifo.sv
// tb/tb_byte_stream_fifo.sv - randomized self-checking bench for byte_stream_fifo against a queue model
module tb_byte_stream_fifo;

    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush_i;
    logic       s_valid_i;
    logic [7:0] s_data_i;
    logic       s_ready_o;
    logic       m_valid_o;
    logic [7:0] m_data_o;
    logic       m_ready_i;
`ifdef BYTE_FIFO_LEVEL_EN
    logic [2:0] level_o;
    logic       almost_full_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    byte_stream_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_ready_o     (s_ready_o),
        .m_valid_o     (m_valid_o),
        .m_data_o      (m_data_o),
        .m_ready_i     (m_ready_i)
`ifdef BYTE_FIFO_LEVEL_EN
        ,
        .level_o       (level_o),
        .almost_full_o (almost_full_o)
`endif
    );

    // Advance one clock and apply the FIFO rules to the model queue.
    task automatic cycle();
        bit push, pop;
        push = rst_n && s_valid_i && !flush_i && (q.size() < DEPTH);
        pop  = rst_n && m_ready_i && !flush_i && (q.size() > 0);
        @(posedge clk);
        #1;
        if (!rst_n || flush_i) q.delete();
        else begin
            if (pop)  q.delete(0);
            if (push) q.push_back(s_data_i);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b exp 1", s_ready_o); end
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b exp 0", m_valid_o); end
        n_checks++; if (m_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got %h exp 00", m_data_o); end
`ifdef BYTE_FIFO_LEVEL_EN
        n_checks++; if (level_o !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level_o); end
        n_checks++; if (almost_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b exp 0", almost_full_o); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        cycle();
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_m_valid got %b exp 0", m_valid_o); end
    endtask

    task automatic test_three_bytes();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        m_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid_i = 1'b1; s_data_i = exp_b[i];
            cycle();
            if (i == 0) begin
                n_checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h11) begin
                    n_fail++; $display("FAIL first_push_latency got v=%b d=%h exp v=1 d=11", m_valid_o, m_data_o); end
            end
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (m_valid_o !== 1'b1 || m_data_o !== exp_b[i] || exp_b[i] !== q[0]) begin
                n_fail++; $display("FAIL three_order[%0d] got v=%b d=%h exp v=1 d=%h", i, m_valid_o, m_data_o, exp_b[i]); end
            cycle();
        end
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL three_empty got %b exp 0", m_valid_o); end
        m_ready_i = 1'b0;
    endtask

    task automatic test_full();
        logic [7:0] got [$];
        m_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid_i = 1'b1; s_data_i = 8'hA0 + 8'(i);
            cycle();
`ifdef BYTE_FIFO_LEVEL_EN
            n_checks++; if (level_o !== 3'(i + 1) || almost_full_o !== ((i + 1) >= AFULL)) begin
                n_fail++; $display("FAIL full_level[%0d] got l=%0d af=%b exp l=%0d af=%b", i, level_o, almost_full_o, i + 1, (i + 1) >= AFULL); end
`endif
        end
        n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_s_ready got %b exp 0", s_ready_o); end
        s_data_i = 8'hA4;
        repeat (2) cycle();
        // Pop from full: the offered byte must not sneak in on the same edge.
        got.push_back(m_data_o);
        m_ready_i = 1'b1;
        cycle();
        m_ready_i = 1'b0;
        n_checks++; if (s_ready_o !== 1'b1 || m_data_o !== 8'hA1) begin
            n_fail++; $display("FAIL pop_from_full got r=%b d=%h exp r=1 d=a1", s_ready_o, m_data_o); end
        cycle();
        s_valid_i = 1'b0;
        n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL a4_accepted got r=%b exp 0", s_ready_o); end
        m_ready_i = 1'b1;
        for (int i = 0; i < 8 && m_valid_o; i++) begin
            got.push_back(m_data_o);
            cycle();
        end
        m_ready_i = 1'b0;
        n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL full_count got %0d exp 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== 8'hA0 + 8'(i)) begin
                n_fail++; $display("FAIL full_order[%0d] got %h exp %h", i, got[i], 8'hA0 + 8'(i)); end
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin s_data_i = 8'($urandom); cycle(); end
        m_ready_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            s_data_i = 8'(i);
            cycle();
            if (m_valid_o !== 1'b1 || s_ready_o !== 1'b1 || m_data_o !== q[0] || q.size() != 2) bad++;
`ifdef BYTE_FIFO_LEVEL_EN
            if (level_o !== 3'd2) bad++;
`endif
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL back_to_back got %0d bad cycles exp 0", bad); end
        n_checks++; if (m_data_o !== 8'hFE) begin n_fail++; $display("FAIL b2b_head got %h exp fe", m_data_o); end
        s_valid_i = 1'b0;
        repeat (2) cycle();
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", m_valid_o); end
        m_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin s_data_i = 8'($urandom); cycle(); end
        flush_i = 1'b1; s_data_i = 8'h5A; m_ready_i = 1'b1;
        cycle();
        flush_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
        n_checks++; if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_state got v=%b r=%b exp v=0 r=1", m_valid_o, s_ready_o); end
`ifdef BYTE_FIFO_LEVEL_EN
        n_checks++; if (level_o !== 3'd0) begin n_fail++; $display("FAIL flush_level got %0d exp 0", level_o); end
`endif
        s_valid_i = 1'b1; s_data_i = 8'h5B;
        cycle();
        s_valid_i = 1'b0;
        n_checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h5B) begin
            n_fail++; $display("FAIL flush_next got v=%b d=%h exp v=1 d=5b", m_valid_o, m_data_o); end
        m_ready_i = 1'b1;
        cycle();
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_single got %b exp 0", m_valid_o); end
        m_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int leaked = 0;
        s_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin s_data_i = 8'hC0 + 8'(i); cycle(); end
        s_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        n_checks++; if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1 || m_data_o !== 8'h00) begin
            n_fail++; $display("FAIL async_reset got v=%b r=%b d=%h exp v=0 r=1 d=00", m_valid_o, s_ready_o, m_data_o); end
        m_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin cycle(); if (m_valid_o !== 1'b0) leaked++; end
        n_checks++; if (leaked != 0) begin n_fail++; $display("FAIL reset_leak got %0d valid cycles exp 0", leaked); end
        m_ready_i = 1'b0;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            s_valid_i = ($urandom_range(0, 3) != 0);
            m_ready_i = ($urandom_range(0, 2) != 0);
            flush_i   = ($urandom_range(0, 59) == 0);
            s_data_i  = 8'($urandom);
            cycle();
            if (m_valid_o !== (q.size() != 0) || s_ready_o !== (q.size() != DEPTH)) bad++;
            else if (q.size() != 0 && m_data_o !== q[0]) bad++;
`ifdef BYTE_FIFO_LEVEL_EN
            if (level_o !== 3'(q.size()) || almost_full_o !== (q.size() >= AFULL)) bad++;
`endif
            if (bad != 0 && bad < 4)
                $display("FAIL random[%0d] got v=%b r=%b d=%h exp size=%0d head=%h", i, m_valid_o, s_ready_o, m_data_o, q.size(), (q.size() != 0) ? q[0] : 8'h00);
        end
        flush_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL random_total got %0d bad cycles exp 0", bad); end
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; s_valid_i = 1'b0; s_data_i = 8'h00; m_ready_i = 1'b0;
        test_reset();
        test_three_bytes();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
